ldm_stm_sequencer: RTL and testbench

LDM_STM_SEQUENCER -- requirements
Module: ldm_stm_sequencer

---
 rtl/mcu_pkg.sv | 16 +
 rtl/lsb_encoder.sv | 25 ++
 rtl/ldm_stm_sequencer.sv | 160 ++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared constants and state encoding for the load/store-multiple sequencer.
package mcu_pkg;

    localparam int unsigned ADDR_STEP_DEF = 4;
    localparam int unsigned REG_COUNT     = 16;
    localparam int unsigned PC_IDX        = 15;
    localparam int unsigned XLEN          = 32;
    localparam int unsigned CNT_W         = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/lsb_encoder.sv
// Combinational lowest-set-bit encoder: index of the lowest set bit plus a valid flag.
module lsb_encoder
    import mcu_pkg::*;
#(
    parameter int unsigned W  = REG_COUNT,
    parameter int unsigned IW = $clog2(W)
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Multi-register load/store sequencer: walks a register list in ascending order,
// issuing one memory transfer per selected register with a req/ack handshake.
module ldm_stm_sequencer
    import mcu_pkg::*;
#(
    parameter int unsigned ADDR_STEP = ADDR_STEP_DEF,
    parameter int unsigned NREGS     = REG_COUNT
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     start,
    input  logic                     is_load,
    input  logic [NREGS-1:0]         reg_list,
    input  logic [XLEN-1:0]          base_addr,
    output logic                     busy,
    output logic                     done,
    output logic [XLEN-1:0]          final_addr,
    output logic                     pc_written,

    output logic [$clog2(NREGS)-1:0] rf_ra,
    input  logic [XLEN-1:0]          rf_rd,
    output logic [$clog2(NREGS)-1:0] rf_wa,
    output logic [XLEN-1:0]          rf_wd,
    output logic                     rf_we,

    output logic                     mem_req,
    output logic                     mem_we,
    output logic [XLEN-1:0]          mem_addr,
    output logic [XLEN-1:0]          mem_wdata,
    input  logic                     mem_ack,
    input  logic [XLEN-1:0]          mem_rdata
);

    localparam int unsigned IDX_W = $clog2(NREGS);

    seq_state_t        state_q;
    seq_state_t        state_d;

    logic              is_load_q;
    logic [NREGS-1:0]  rem_q;
    logic [XLEN-1:0]   base_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              pc_q;

    logic [IDX_W-1:0]  sel_idx;
    logic              sel_valid;
    logic [NREGS-1:0]  sel_mask;
    logic [NREGS-1:0]  rem_after;
    logic              ack_fire;
    logic              last_ack;
    logic [XLEN-1:0]   cur_addr;

    // Lowest remaining register is the next one to transfer.
    lsb_encoder #(
        .W  (NREGS),
        .IW (IDX_W)
    ) u_lsb (
        .vec   (rem_q),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    // Handshake bookkeeping; acks without an outstanding request never fire.
    always_comb begin
        sel_mask  = NREGS'(1) << sel_idx;
        rem_after = rem_q & ~sel_mask;
        ack_fire  = (state_q == ST_XFER) && sel_valid && mem_ack;
        last_ack  = ack_fire && (rem_after == '0);
        cur_addr  = base_q + (32'(ADDR_STEP) * 32'(cnt_q));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (reg_list != '0) ? ST_XFER : ST_DONE;
                end
            end
            ST_XFER: begin
                if (last_ack) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Command latch, remaining-list and transfer-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_load_q <= 1'b0;
            rem_q     <= '0;
            base_q    <= '0;
            cnt_q     <= '0;
            pc_q      <= 1'b0;
        end else if (state_q == ST_IDLE && start) begin
            is_load_q <= is_load;
            rem_q     <= reg_list;
            base_q    <= base_addr;
            cnt_q     <= '0;
            pc_q      <= is_load && reg_list[PC_IDX];
        end else if (ack_fire) begin
            rem_q     <= rem_after;
            cnt_q     <= cnt_q + CNT_W'(1);
        end
    end

    // Output decode; everything is zero in IDLE so reset clears all outputs.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        final_addr = '0;
        pc_written = 1'b0;
        rf_ra      = '0;
        rf_wa      = '0;
        rf_wd      = '0;
        rf_we      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            ST_XFER: begin
                busy     = 1'b1;
                mem_req  = sel_valid;
                mem_we   = ~is_load_q;
                mem_addr = cur_addr;
                if (!is_load_q) begin
                    rf_ra     = sel_idx;
                    mem_wdata = rf_rd;
                end else if (ack_fire) begin
                    rf_we = 1'b1;
                    rf_wa = sel_idx;
                    rf_wd = mem_rdata;
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                final_addr = cur_addr;
                pc_written = pc_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Self-checking bench: vector table of operations, scoreboard of expected transfers.
module tb_ldm_stm_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_load;
    logic [15:0] reg_list;
    logic [31:0] base_addr;
    logic        busy;
    logic        done;
    logic [31:0] final_addr;
    logic        pc_written;
    logic [3:0]  rf_ra;
    logic [31:0] rf_rd;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        rf_we;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rf_model [16];

    typedef struct {
        logic        ld;
        logic [15:0] list;
        logic [31:0] base;
        int          delay;
        bit          stray;
        bit          busy_start;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
        logic [3:0]  idx;
        int          cyc;
    } xfer_t;

    xfer_t q[$];

    localparam int NV = 8;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a ^ 32'hC3C3_5A5A) + 32'h0000_0101;
    endfunction

    assign rf_rd     = rf_model[rf_ra];
    assign mem_rdata = mem_ack ? mem_fn(mem_addr) : 32'hDEAD_BEEF;

    ldm_stm_sequencer #(.ADDR_STEP(4), .NREGS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_load    (is_load),
        .reg_list   (reg_list),
        .base_addr  (base_addr),
        .busy       (busy),
        .done       (done),
        .final_addr (final_addr),
        .pc_written (pc_written),
        .rf_ra      (rf_ra),
        .rf_rd      (rf_rd),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .rf_we      (rf_we),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctrl"}, 32'({busy, done, pc_written, mem_req, mem_we, rf_we}), 32'h0);
        chk({tag, "_final_addr"}, final_addr, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_rf_idx"}, 32'({rf_ra, rf_wa}), 32'h0);
        chk({tag, "_rf_wd"}, rf_wd, 32'h0);
    endtask

    // Runs one operation, cycle by cycle, against the scoreboard built from the vector.
    task automatic run_op(input vec_t v);
        int    n;
        int    wcnt;
        int    exp_done;
        bit    seen;
        xfer_t e;
        q.delete();
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (v.list[i]) begin
                e.addr = v.base + 32'(n * 4);
                e.we   = !v.ld;
                e.idx  = 4'(i);
                e.data = v.ld ? mem_fn(e.addr) : rf_model[i];
                e.cyc  = 1 + n * (v.delay + 1) + v.delay;
                q.push_back(e);
                n++;
            end
        end
        exp_done = n * (v.delay + 1) + 1;

        @(posedge clk); #1;
        start     = 1'b1;
        is_load   = v.ld;
        reg_list  = v.list;
        base_addr = v.base;
        mem_ack   = v.stray;
        wcnt      = 0;
        seen      = 1'b0;

        for (int c = 1; c <= 300 && !seen; c++) begin
            @(posedge clk); #1;
            if (v.busy_start) begin
                start     = 1'b1;
                reg_list  = 16'($urandom);
                is_load   = ~v.ld;
                base_addr = $urandom;
            end else begin
                start = 1'b0;
            end
            if (mem_req) begin
                if (wcnt == v.delay) begin
                    mem_ack = 1'b1;
                    wcnt    = 0;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack = v.stray;
            end
            @(negedge clk);
            chk("busy", 32'(busy), 32'h1);
            if (mem_req) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req actual=mem_req@cycle%0d required=no_request", c);
                end else begin
                    chk("mem_addr", mem_addr, q[0].addr);
                    chk("mem_we", 32'(mem_we), 32'(q[0].we));
                    if (!v.ld) chk("mem_wdata", mem_wdata, q[0].data);
                    if (mem_ack) begin
                        chk("ack_cycle", 32'(c), 32'(q[0].cyc));
                        if (v.ld) begin
                            chk("rf_we", 32'(rf_we), 32'h1);
                            chk("rf_wa", 32'(rf_wa), 32'(q[0].idx));
                            chk("rf_wd", rf_wd, q[0].data);
                        end else begin
                            chk("rf_we_stm", 32'(rf_we), 32'h0);
                        end
                        void'(q.pop_front());
                    end else begin
                        chk("rf_we_wait", 32'(rf_we), 32'h0);
                    end
                end
            end else begin
                chk("rf_we_noreq", 32'(rf_we), 32'h0);
            end
            if (done) begin
                seen = 1'b1;
                chk("done_cycle", 32'(c), 32'(exp_done));
                chk("xfers_left", 32'(q.size()), 32'h0);
                chk("final_addr", final_addr, v.base + 32'(n * 4));
                chk("pc_written", 32'(pc_written), 32'(v.ld & v.list[15]));
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done required=done_by_cycle%0d", exp_done);
        end

        @(posedge clk); #1;
        start   = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("busy_after", 32'(busy), 32'h0);
        chk("done_after", 32'(done), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) rf_model[i] = 32'hA000_0000 + 32'(i) * 32'h0111_0011;

        //          ld    list        base           dly stray bstart
        vecs[0] = '{1'b0, 16'h0005, 32'h0000_1000, 0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'h8001, 32'h0000_2000, 2, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 16'h0000, 32'h0000_3000, 0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 16'h0003, 32'hFFFF_FFFC, 0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 16'h00A6, 32'h0000_4000, 1, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 16'h0000, 32'h0000_5550, 0, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 16'h8421, 32'h0000_6000, 0, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 16'h8000, 32'h0000_7000, 3, 1'b0, 1'b0};

        rst       = 1'b1;
        start     = 1'b0;
        is_load   = 1'b0;
        reg_list  = 16'h0;
        base_addr = 32'h0;
        mem_ack   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) run_op(vecs[i]);

        // Reset in the middle of a full-list load aborts cleanly.
        @(posedge clk); #1;
        start     = 1'b1;
        is_load   = 1'b1;
        reg_list  = 16'hFFFF;
        base_addr = 32'h0000_8000;
        @(posedge clk); #1;
        start   = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        chk("abort_rf_we0", 32'(rf_we), 32'h1);
        chk("abort_rf_wa0", 32'(rf_wa), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_rf_wa1", 32'(rf_wa), 32'h1);
        chk("abort_addr1", mem_addr, 32'h0000_8004);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero("abort");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("post_abort_quiet", 32'({busy, done, mem_req, rf_we}), 32'h0);
        end
        mem_ack = 1'b0;

        run_op('{1'b0, 16'h0011, 32'h0000_9000, 1, 1'b0, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
